// File: rtl/div.sv
// Iterative unsigned restoring divider.
// One quotient bit per clock; level-held ctrl_enable / ctrl_done handshake.
// Divide-by-zero skips the iteration and reports all-ones quotient with the
// dividend as remainder.
module div #(
    parameter int in_width = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [in_width-1:0] data_dividend,
    input  logic [in_width-1:0] data_divisor,
    input  logic                ctrl_enable,
    output logic [in_width-1:0] data_quotient,
    output logic [in_width-1:0] data_remainder,
    output logic                ctrl_div_zero,
    output logic                ctrl_done
);

    localparam int CW = (in_width > 1) ? $clog2(in_width) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [in_width-1:0] r_q;          // dividend shifting out, quotient shifting in
    logic [in_width-1:0] r_d;          // latched divisor
    logic [in_width:0]   r_rem;        // partial remainder, one guard bit
    logic [CW-1:0]       r_count;
    logic [in_width-1:0] r_quotient;
    logic [in_width-1:0] r_remainder;
    logic                r_div_zero;
    logic                r_done;

    logic [in_width:0]   w_shift;
    logic [in_width:0]   w_trial;
    logic                w_qbit;
    logic [in_width:0]   w_rem_next;
    logic [in_width-1:0] w_q_next;
    logic                w_last;
    logic                w_divisor_zero;

    // One restoring step: bring down the next dividend bit and try to subtract.
    always_comb begin
        w_shift    = {r_rem[in_width-1:0], r_q[in_width-1]};
        w_trial    = w_shift - {1'b0, r_d};
        w_qbit     = ~w_trial[in_width];
        w_rem_next = w_qbit ? w_trial : w_shift;
        w_q_next   = {r_q[in_width-2:0], w_qbit};
    end

    assign w_last         = (r_count == CW'(in_width - 1));
    assign w_divisor_zero = (data_divisor == '0);

    // Next-state logic for the handshake/iteration sequencer.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (ctrl_enable) w_state_next = S_LOAD;
            S_LOAD: w_state_next = w_divisor_zero ? S_DONE : S_RUN;
            S_RUN:  if (w_last) w_state_next = S_DONE;
            S_DONE: if (!ctrl_enable) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // Datapath and registered results; results hold outside LOAD/RUN completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q         <= '0;
            r_d         <= '0;
            r_rem       <= '0;
            r_count     <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_div_zero  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    r_q     <= data_dividend;
                    r_d     <= data_divisor;
                    r_rem   <= '0;
                    r_count <= '0;
                    if (w_divisor_zero) begin
                        r_quotient  <= '1;
                        r_remainder <= data_dividend;
                        r_div_zero  <= 1'b1;
                        r_done      <= 1'b1;
                    end else begin
                        r_div_zero  <= 1'b0;
                        r_done      <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_rem   <= w_rem_next;
                    r_q     <= w_q_next;
                    r_count <= r_count + 1'b1;
                    if (w_last) begin
                        r_quotient  <= w_q_next;
                        r_remainder <= w_rem_next[in_width-1:0];
                        r_done      <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (!ctrl_enable) r_done <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign data_quotient  = r_quotient;
    assign data_remainder = r_remainder;
    assign ctrl_div_zero  = r_div_zero;
    assign ctrl_done      = r_done;

endmodule

// File: tb/tb_div.sv
// Directed and random checks for the iterative divider.
module tb_div;

    localparam int W = 8;
    localparam int LAT_NORM = W + 2;   // edges counted from E0 inclusive
    localparam int LAT_ZERO = 2;

    logic         clk;
    logic         rst;
    logic [W-1:0] data_dividend;
    logic [W-1:0] data_divisor;
    logic         ctrl_enable;
    logic [W-1:0] data_quotient;
    logic [W-1:0] data_remainder;
    logic         ctrl_div_zero;
    logic         ctrl_done;

    int checks = 0;
    int passes = 0;

    div #(.in_width(W)) dut (
        .clk            (clk),
        .rst            (rst),
        .data_dividend  (data_dividend),
        .data_divisor   (data_divisor),
        .ctrl_enable    (ctrl_enable),
        .data_quotient  (data_quotient),
        .data_remainder (data_remainder),
        .ctrl_div_zero  (ctrl_div_zero),
        .ctrl_done      (ctrl_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Start an operation and wait (bounded) for ctrl_done; enable stays high.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic dz, output int lat);
        @(negedge clk);
        data_dividend = a;
        data_divisor  = b;
        ctrl_enable   = 1'b1;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!ctrl_done && lat < 40);
        q  = data_quotient;
        r  = data_remainder;
        dz = ctrl_div_zero;
    endtask

    // Drop enable and let DONE return to IDLE.
    task automatic finish_op(output logic done_after);
        @(negedge clk);
        ctrl_enable = 1'b0;
        @(posedge clk); #1;
        done_after = ctrl_done;
    endtask

    task automatic test_reset();
        rst = 1'b1; ctrl_enable = 1'b0; data_dividend = '0; data_divisor = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({ctrl_done, ctrl_div_zero, data_quotient, data_remainder} !== '0)
            $display("FAIL reset_outputs: got done=%0b dz=%0b q=%0d r=%0d, want all 0",
                     ctrl_done, ctrl_div_zero, data_quotient, data_remainder);
        else passes++;
        @(negedge clk); rst = 1'b0;
        $display("reset: done=%0b dz=%0b q=%0d r=%0d", ctrl_done, ctrl_div_zero, data_quotient, data_remainder);
    endtask

    task automatic test_basic();
        logic [W-1:0] q, r; logic dz, d0; int lat;
        do_op(8'd100, 8'd7, q, r, dz, lat);
        $display("op 100/7: q=%0d r=%0d dz=%0b lat=%0d", q, r, dz, lat);
        checks++; if (lat !== LAT_NORM) $display("FAIL basic_latency: got %0d want %0d", lat, LAT_NORM); else passes++;
        checks++; if (q !== 8'd14) $display("FAIL basic_q: got %0d want 14", q); else passes++;
        checks++; if (r !== 8'd2) $display("FAIL basic_r: got %0d want 2", r); else passes++;
        checks++; if (dz !== 1'b0) $display("FAIL basic_dz: got %0b want 0", dz); else passes++;
        finish_op(d0);
        checks++; if (d0 !== 1'b0) $display("FAIL basic_done_drop: got %0b want 0", d0); else passes++;
    endtask

    task automatic test_edges();
        logic [W-1:0] va [4] = '{8'd255, 8'd5, 8'd255, 8'd0};
        logic [W-1:0] vb [4] = '{8'd1,   8'd9, 8'd255, 8'd3};
        logic [W-1:0] eq [4] = '{8'd255, 8'd0, 8'd1,   8'd0};
        logic [W-1:0] er [4] = '{8'd0,   8'd5, 8'd0,   8'd0};
        logic [W-1:0] q, r; logic dz, d0; int lat;
        for (int i = 0; i < 4; i++) begin
            do_op(va[i], vb[i], q, r, dz, lat);
            $display("op %0d/%0d: q=%0d r=%0d dz=%0b lat=%0d", va[i], vb[i], q, r, dz, lat);
            checks++; if (q !== eq[i]) $display("FAIL edge_q %0d/%0d: got %0d want %0d", va[i], vb[i], q, eq[i]); else passes++;
            checks++; if (r !== er[i]) $display("FAIL edge_r %0d/%0d: got %0d want %0d", va[i], vb[i], r, er[i]); else passes++;
            checks++; if (lat !== LAT_NORM) $display("FAIL edge_latency: got %0d want %0d", lat, LAT_NORM); else passes++;
            finish_op(d0);
        end
    endtask

    task automatic test_div_zero();
        logic [W-1:0] q, r; logic dz, d0; int lat;
        do_op(8'd200, 8'd0, q, r, dz, lat);
        $display("op 200/0: q=%0d r=%0d dz=%0b lat=%0d", q, r, dz, lat);
        checks++; if (lat !== LAT_ZERO) $display("FAIL dz_latency: got %0d want %0d", lat, LAT_ZERO); else passes++;
        checks++; if (q !== 8'd255) $display("FAIL dz_q: got %0d want 255", q); else passes++;
        checks++; if (r !== 8'd200) $display("FAIL dz_r: got %0d want 200", r); else passes++;
        checks++; if (dz !== 1'b1) $display("FAIL dz_flag: got %0b want 1", dz); else passes++;
        finish_op(d0);
        checks++; if (ctrl_div_zero !== 1'b1) $display("FAIL dz_hold_idle: got %0b want 1", ctrl_div_zero); else passes++;
        do_op(8'd10, 8'd3, q, r, dz, lat);
        $display("op 10/3: q=%0d r=%0d dz=%0b lat=%0d", q, r, dz, lat);
        checks++; if (dz !== 1'b0) $display("FAIL dz_clear: got %0b want 0", dz); else passes++;
        checks++; if (q !== 8'd3 || r !== 8'd1) $display("FAIL dz_follow: got q=%0d r=%0d want q=3 r=1", q, r); else passes++;
        finish_op(d0);
    endtask

    task automatic test_hold();
        logic [W-1:0] q, r; logic dz, d0; int lat;
        do_op(8'd77, 8'd5, q, r, dz, lat);
        $display("op 77/5: q=%0d r=%0d dz=%0b lat=%0d", q, r, dz, lat);
        checks++; if (q !== 8'd15 || r !== 8'd2) $display("FAIL hold_result: got q=%0d r=%0d want q=15 r=2", q, r); else passes++;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (ctrl_done !== 1'b1 || data_quotient !== 8'd15 || data_remainder !== 8'd2)
                $display("FAIL hold_stable cycle %0d: got done=%0b q=%0d r=%0d want done=1 q=15 r=2",
                         i, ctrl_done, data_quotient, data_remainder);
            else passes++;
        end
        finish_op(d0);
        checks++; if (d0 !== 1'b0) $display("FAIL hold_drop: got done=%0b want 0", d0); else passes++;
        do_op(8'd81, 8'd9, q, r, dz, lat);
        $display("op 81/9: q=%0d r=%0d dz=%0b lat=%0d", q, r, dz, lat);
        checks++; if (q !== 8'd9 || r !== 8'd0) $display("FAIL hold_next: got q=%0d r=%0d want q=9 r=0", q, r); else passes++;
        finish_op(d0);
    endtask

    task automatic test_reset_mid_run();
        logic [W-1:0] q, r; logic dz, d0; int lat;
        @(negedge clk);
        data_dividend = 8'd100; data_divisor = 8'd7; ctrl_enable = 1'b1;
        // E0 (to LOAD), E0+1 (LOAD), E0+2 and E0+3 are steps 1 and 2
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1; ctrl_enable = 1'b0;   // sampled at the 3rd-step edge
        @(posedge clk); #1;
        checks++;
        if ({ctrl_done, ctrl_div_zero, data_quotient, data_remainder} !== '0)
            $display("FAIL midrst_outputs: got done=%0b dz=%0b q=%0d r=%0d want all 0",
                     ctrl_done, ctrl_div_zero, data_quotient, data_remainder);
        else passes++;
        @(negedge clk); rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        checks++; if (ctrl_done !== 1'b0) $display("FAIL midrst_idle: got done=%0b want 0", ctrl_done); else passes++;
        $display("reset during RUN: done=%0b q=%0d r=%0d", ctrl_done, data_quotient, data_remainder);
        do_op(8'd50, 8'd6, q, r, dz, lat);
        $display("op 50/6: q=%0d r=%0d dz=%0b lat=%0d", q, r, dz, lat);
        checks++; if (q !== 8'd8 || r !== 8'd2 || lat !== LAT_NORM)
            $display("FAIL midrst_follow: got q=%0d r=%0d lat=%0d want q=8 r=2 lat=%0d", q, r, lat, LAT_NORM);
        else passes++;
        finish_op(d0);
    endtask

    task automatic test_operand_change();
        logic d0; int lat;
        @(negedge clk);
        data_dividend = 8'd173; data_divisor = 8'd11; ctrl_enable = 1'b1;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (lat >= 2) begin
                data_dividend = W'($urandom);
                data_divisor  = W'($urandom);
            end
        end while (!ctrl_done && lat < 40);
        $display("op 173/11 with churning inputs: q=%0d r=%0d lat=%0d", data_quotient, data_remainder, lat);
        checks++; if (data_quotient !== 8'd15 || data_remainder !== 8'd8 || lat !== LAT_NORM)
            $display("FAIL churn: got q=%0d r=%0d lat=%0d want q=15 r=8 lat=%0d",
                     data_quotient, data_remainder, lat, LAT_NORM);
        else passes++;
        finish_op(d0);
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, q, r, eq, er; logic dz, d0; int lat, el;
        for (int i = 0; i < 1000; i++) begin
            a = W'($urandom_range(0, 255));
            b = (i % 50 == 7) ? 8'd0 : W'($urandom_range(0, 255));
            if (b == 0) begin eq = 8'd255; er = a; el = LAT_ZERO; end
            else        begin eq = a / b;  er = a % b; el = LAT_NORM; end
            do_op(a, b, q, r, dz, lat);
            $display("rand %0d: %0d/%0d q=%0d r=%0d dz=%0b lat=%0d", i, a, b, q, r, dz, lat);
            checks++; if (lat !== el) $display("FAIL rand_protocol %0d/%0d: done at edge %0d want %0d", a, b, lat, el); else passes++;
            checks++; if (q !== eq || r !== er || dz !== (b == 0))
                $display("FAIL rand_result %0d/%0d: got q=%0d r=%0d dz=%0b want q=%0d r=%0d dz=%0b",
                         a, b, q, r, dz, eq, er, (b == 0));
            else passes++;
            finish_op(d0);
            checks++; if (d0 !== 1'b0) $display("FAIL rand_done_drop: got %0b want 0", d0); else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_edges();
        test_div_zero();
        test_hold();
        test_reset_mid_run();
        test_operand_change();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
